// File: rtl/alu_core.sv
// Purpose : 32-bit integer ALU for the execute stage (add/sub, logic ops, shifts, set-less-than, pass-B).
// Latency : 1 cycle; alu_result, zero and out_valid are registered together on the rising edge of clk.
// Backpr. : none; a new operation can be issued every cycle, results are never stalled.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset (overrides in_valid)
//   in_valid    a / b / alu_ctl hold an operation this cycle
//   alu_ctl     operation select, see alu_op_e below (11-15 reserved -> result 0)
//   a, b        operands; b also supplies the shift amount (low $clog2(WIDTH) bits)
//   alu_result  registered result, held while in_valid is low
//   zero        registered, 1 when alu_result == 0 (branch resolution)
//   out_valid   alu_result/zero were produced by an in_valid cycle on the previous edge

module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             out_valid
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSB = 4'd10
  } alu_op_e;

  alu_op_e op;
  assign op = alu_op_e'(alu_ctl);

  // ---------------------------------------------------------------------------
  // Shared adder. SUB, SLT and SLTU all need a - b, so one adder is reused:
  // a - b = a + ~b + 1. The extra top bit is the carry-out, which for the
  // subtract case is the inverted borrow (carry=1 <=> a >= b unsigned).
  // ---------------------------------------------------------------------------
  logic             sub_mode;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  assign sub_mode  = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign add_b     = sub_mode ? ~b : b;
  assign sum_ext   = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, sub_mode};
  assign sum       = sum_ext[WIDTH-1:0];
  assign carry_out = sum_ext[WIDTH];

  // Unsigned less-than is simply "a - b borrowed".
  logic lt_unsigned;
  assign lt_unsigned = ~carry_out;

  // Signed less-than: when the signs differ the difference can overflow, so
  // the answer is just the sign of a; when they agree the difference cannot
  // overflow and its sign bit is the answer.
  logic sign_a;
  logic sign_b;
  logic lt_signed;
  assign sign_a    = a[WIDTH-1];
  assign sign_b    = b[WIDTH-1];
  assign lt_signed = (sign_a ^ sign_b) ? sign_a : sum[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Shifter. Only the low SHW bits of b are used; the upper bits are ignored
  // so that shift amounts wrap modulo WIDTH.
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr_logic;
  logic [WIDTH-1:0] shr_arith;

  assign shamt     = b[SHW-1:0];
  assign shl       = a << shamt;
  assign shr_logic = a >> shamt;
  assign shr_arith = $unsigned($signed(a) >>> shamt);

  // ---------------------------------------------------------------------------
  // Result select. Reserved encodings fall into the default arm and produce 0,
  // so no control value can leave the result undefined.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] result_nxt;

  always_comb begin
    result_nxt = '0;
    case (op)
      OP_ADD:   result_nxt = sum;
      OP_SUB:   result_nxt = sum;
      OP_AND:   result_nxt = a & b;
      OP_OR:    result_nxt = a | b;
      OP_XOR:   result_nxt = a ^ b;
      OP_SLL:   result_nxt = shl;
      OP_SRL:   result_nxt = shr_logic;
      OP_SRA:   result_nxt = shr_arith;
      OP_SLT:   result_nxt = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU:  result_nxt = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_PASSB: result_nxt = b;
      default:  result_nxt = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers. zero is registered alongside the result from the very
  // same next-state value, so it always matches the registered alu_result and
  // never reflects the current inputs. Result and flag hold when idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0;
      zero       <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_result <= result_nxt;
        zero       <= (result_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Purpose : self-checking bench for alu_core using an expected-result queue.
// Latency : each issued cycle pushes one expectation, popped one edge later.
// Backpr. : none; stimulus is issued back-to-back every cycle.

module tb_alu_core;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             out_valid;

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .alu_ctl    (alu_ctl),
    .a          (a),
    .b          (b),
    .alu_result (alu_result),
    .zero       (zero),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             v;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_res;
  logic             model_z;
  int               n_checks;
  int               n_errors;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference behaviour written directly from the operation table.
  function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] ctl, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    int unsigned sh;
    logic [WIDTH-1:0] r;
    sh = y % WIDTH;
    r  = '0;
    case (ctl)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = x << sh;
      4'd6:  r = x >> sh;
      4'd7:  begin
               r = x >> sh;
               if (x[WIDTH-1])
                 for (int i = 0; i < WIDTH; i++)
                   if (i >= WIDTH - int'(sh)) r[i] = 1'b1;
             end
      4'd8:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd9:  r = (x < y) ? 1 : 0;
      4'd10: r = y;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drive one cycle of stimulus, push what the DUT must show after the edge,
  // then pop and compare one time unit past that edge.
  task automatic issue(input string tag, input logic r, input logic v, input logic [3:0] ctl,
                       input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    rst      = r;
    in_valid = v;
    alu_ctl  = ctl;
    a        = x;
    b        = y;
    if (r) begin
      model_res = '0;
      model_z   = 1'b1;
      e.v       = 1'b0;
    end else if (v) begin
      model_res = ref_alu(ctl, x, y);
      model_z   = (model_res == '0);
      e.v       = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.res = model_res;
    e.z   = model_z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " result"}, alu_result, e.res);
      check({tag, " zero"}, {31'd0, zero}, {31'd0, e.z});
      check({tag, " valid"}, {31'd0, out_valid}, {31'd0, e.v});
    end
  endtask

  // Direct checks of literal values, independent of the reference model.
  task automatic expect_lit(input string tag, input logic [WIDTH-1:0] res, input logic z, input logic v);
    check({tag, " lit_result"}, alu_result, res);
    check({tag, " lit_zero"}, {31'd0, zero}, {31'd0, z});
    check({tag, " lit_valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  logic [WIDTH-1:0] sweep_exp [9];
  logic [WIDTH-1:0] specials [6];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    model_res = '0;
    model_z   = 1'b1;

    // Reset with in_valid high: reset must win.
    issue("reset", 1'b1, 1'b1, 4'd0, 32'd5, 32'd7);
    expect_lit("reset", 32'd0, 1'b1, 1'b0);

    // Back-to-back sweep of ctl 0..8 with a=10, b=15.
    sweep_exp[0] = 32'd25;       sweep_exp[1] = 32'hFFFF_FFFB; sweep_exp[2] = 32'd10;
    sweep_exp[3] = 32'd15;       sweep_exp[4] = 32'd5;         sweep_exp[5] = 32'h0005_0000;
    sweep_exp[6] = 32'd0;        sweep_exp[7] = 32'd0;         sweep_exp[8] = 32'd1;
    for (int i = 0; i < 9; i++) begin
      issue($sformatf("sweep%0d", i), 1'b0, 1'b1, 4'(i), 32'd10, 32'd15);
      expect_lit($sformatf("sweep%0d", i), sweep_exp[i], sweep_exp[i] == 0, 1'b1);
    end

    // Wrap-around.
    issue("add_wrap", 1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
    expect_lit("add_wrap", 32'd0, 1'b1, 1'b1);
    issue("sub_wrap", 1'b0, 1'b1, 4'd1, 32'd0, 32'd1);
    expect_lit("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue("add_ovf", 1'b0, 1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1);
    expect_lit("add_ovf", 32'h8000_0000, 1'b0, 1'b1);

    // Signed vs unsigned.
    issue("slt_neg", 1'b0, 1'b1, 4'd8, 32'h8000_0000, 32'd1);
    expect_lit("slt_neg", 32'd1, 1'b0, 1'b1);
    issue("sltu_neg", 1'b0, 1'b1, 4'd9, 32'h8000_0000, 32'd1);
    expect_lit("sltu_neg", 32'd0, 1'b1, 1'b1);
    issue("sra31", 1'b0, 1'b1, 4'd7, 32'h8000_0000, 32'd31);
    expect_lit("sra31", 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue("srl31", 1'b0, 1'b1, 4'd6, 32'h8000_0000, 32'd31);
    expect_lit("srl31", 32'd1, 1'b0, 1'b1);

    // Shift amount masking, shift by zero, pass-B, reserved code.
    issue("sll_mask", 1'b0, 1'b1, 4'd5, 32'd1, 32'h21);
    expect_lit("sll_mask", 32'd2, 1'b0, 1'b1);
    issue("sll_zero", 1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    expect_lit("sll_zero", 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue("passb", 1'b0, 1'b1, 4'd10, 32'h1234_5678, 32'hCAFE_F00D);
    expect_lit("passb", 32'hCAFE_F00D, 1'b0, 1'b1);
    issue("rsvd12", 1'b0, 1'b1, 4'd12, 32'hFFFF_FFFF, 32'h1234_5678);
    expect_lit("rsvd12", 32'd0, 1'b1, 1'b1);

    // Hold: in_valid low keeps result, drops out_valid.
    issue("pre_hold", 1'b0, 1'b1, 4'd3, 32'hF0, 32'h0F);
    issue("hold", 1'b0, 1'b0, 4'd0, 32'd1, 32'd1);
    expect_lit("hold", 32'hFF, 1'b0, 1'b0);

    // Reset in the middle of a stream, then resume.
    issue("pre_rst", 1'b0, 1'b1, 4'd0, 32'd100, 32'd200);
    issue("mid_rst", 1'b1, 1'b1, 4'd0, 32'd100, 32'd200);
    expect_lit("mid_rst", 32'd0, 1'b1, 1'b0);
    issue("post_rst", 1'b0, 1'b1, 4'd1, 32'd50, 32'd8);
    expect_lit("post_rst", 32'd42, 1'b0, 1'b1);

    // Randomised stream, mixed with corner operand values.
    specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000;
    specials[3] = 32'h7FFF_FFFF; specials[4] = 32'h0000_0001; specials[5] = 32'h0000_001F;
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
      issue($sformatf("rand%0d", n), $urandom_range(0, 31) == 0, $urandom_range(0, 4) != 0,
            4'($urandom_range(0, 15)), ra, rb);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
